data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressable data RAM for the RV32I core's load/store stage.
- Read is combinational: asynchronous read returning zero-extended byte, halfword or word.
- Write is synchronous: one byte, halfword or word on the rising clock edge.
- Sign extension for LB/LH is done by the core, not here.

Parameters:
- DEPTH_BYTES, 1024, number of byte locations; must be a power of two ≥ 4.
- ADDR_BITS, $clog2(DEPTH_BYTES), derived; number of address bits decoded.

Ports:
- clk_i  input  1  system clock; writes occur on its rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- mem_write_i  input  1  write enable, sampled on the rising clk_i edge.
- req_size_i  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = word.
- addr_i  input  32  byte address; only addr_i[ADDR_BITS-1:0] is decoded, upper bits are ignored.
- data_i  input  32  write data, least-significant bytes used per size.
- data_o  output  32  read data, zero-extended per size.

Behaviour:
- Storage is DEPTH_BYTES 8-bit locations, little-endian.
- A = addr_i[ADDR_BITS-1:0]. Byte k of an access maps to location (A+k) mod DEPTH_BYTES, so accesses wrap at the top of memory.
- Read (combinational, independent of mem_write_i):
  - Byte: data_o = {24'b0, M[A]}.
  - Halfword: data_o = {16'b0, M[A+1], M[A]}.
  - Word: data_o = {M[A+3], M[A+2], M[A+1], M[A]}.
- Write, on the rising clk_i edge with reset_i=1 and mem_write_i=1:
  - Byte: M[A] <= data_i[7:0].
  - Halfword: additionally M[A+1] <= data_i[15:8].
  - Word: additionally M[A+2] <= data_i[23:16] and M[A+3] <= data_i[31:24].
  - Bytes outside the access size are untouched.
- Read-during-write: data_o shows old contents until the edge, then new contents in the same cycle after the edge. No internal pipeline: write-to-read latency is one edge.
- Misaligned accesses are legal and performed byte-wise with the wrap rule above.
- Reset:
  - reset_i=0 asynchronously clears every location to 8'h00, so data_o = 32'h0 while reset is held.
  - Writes are inhibited while reset_i=0.
  - Release is synchronous-safe: the first write can occur at the first rising edge with reset_i=1.
- Reset mid-operation: a write at the same edge as reset assertion is discarded; memory is all-zero afterwards.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro DATA_MEMORY_ALIGN_CHECK_EN.
- When defined:
  - Adds output port misalign_o (1 bit, last in the port list).
  - misalign_o is combinational, high when req_size_i=01 and A[0]=1, or when the size is word and A[1:0]≠00.
  - While misalign_o=1, writes are suppressed and data_o = 32'h0.
- When not defined: no misalign_o port; misaligned accesses behave as described in Behaviour.

Test Plan:
- Reset then read: hold reset_i=0 for 2 cycles, release, read word at 0, 1 and 2 -> 32'h00000000 each; repeat for byte and halfword sizes -> 0.
- Byte write: size 00, addr 0, data_i 32'hAABBCCFF, write one edge. Then:
  - Byte reads at addr 0/1/2 -> 000000FF / 00000000 / 00000000.
  - Word read at 0 -> 000000FF.
- Halfword write: size 01, addr 0, data_i 0000FFFF. Then:
  - Halfword read at 0 -> 0000FFFF; at 1 -> 000000FF; at 2 -> 00000000.
  - Word read at 0 -> 0000FFFF.
- Word write and sub-word reads: size 10, addr 4, data_i AABBCCDD. Then:
  - Byte reads at 4..7 -> DD, CC, BB, AA (zero-extended).
  - Halfword at 5 -> 0000BBCC.
  - Word at 5 -> 00AABBCC, with byte 8 still 00.
- Wrap and reset mid-run:
  - Word write 11223344 at DEPTH_BYTES-2 -> M[last-1]=44, M[last]=33, M[0]=22, M[1]=11; word read at DEPTH_BYTES-2 returns 11223344.
  - Then assert reset_i=0 between edges -> data_o is 0 immediately, with no clock edge needed.
- With DATA_MEMORY_ALIGN_CHECK_EN: word write DEADBEEF at addr 2 -> misalign_o=1, data_o=0, memory unchanged; subsequent aligned word read at 0 -> prior contents.

Source files
------------

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Byte-addressable little-endian data RAM with combinational
//               zero-extended reads, synchronous byte/half/word writes, and
//               an asynchronous active-low clear. Accesses wrap at the top.
//               Optional macro DATA_MEMORY_ALIGN_CHECK_EN adds misalign_o and
//               blocks misaligned half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_write_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    output logic [31:0] data_o,
    output logic        misalign_o
`else
    output logic [31:0] data_o
`endif
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;

    logic [7:0]           r_mem [DEPTH_BYTES];
    logic [ADDR_BITS-1:0] w_base;
    logic [ADDR_BITS-1:0] w_lane_addr [4];
    logic [7:0]           w_lane_rd   [4];
    logic                 w_is_byte;
    logic                 w_is_half;
    logic                 w_misalign;
    logic                 w_write_en;
    logic [31:0]          w_rd_data;
    logic                 w_unused_addr;

    assign w_base        = addr_i[ADDR_BITS-1:0];
    assign w_unused_addr = ^addr_i[31:ADDR_BITS];
    assign w_is_byte     = (req_size_i == c_SIZE_BYTE);
    assign w_is_half     = (req_size_i == c_SIZE_HALF);

    // Each lane k addresses (A+k); the natural ADDR_BITS overflow gives the wrap.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_lane_addr[k] = w_base + ADDR_BITS'(k);
        assign w_lane_rd[k]   = r_mem[w_lane_addr[k]];
    end

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    assign w_misalign = (w_is_half && w_base[0]) ||
                        (!w_is_byte && !w_is_half && (w_base[1:0] != 2'b00));
    assign misalign_o = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_write_en = mem_write_i && !w_misalign;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_write_en) begin
            r_mem[w_lane_addr[0]] <= data_i[7:0];
            if (!w_is_byte) begin
                r_mem[w_lane_addr[1]] <= data_i[15:8];
            end
            if (!w_is_byte && !w_is_half) begin
                r_mem[w_lane_addr[2]] <= data_i[23:16];
                r_mem[w_lane_addr[3]] <= data_i[31:24];
            end
        end
    end

    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (w_is_byte) begin
            w_rd_data = {24'h00_0000, w_lane_rd[0]};
        end else if (w_is_half) begin
            w_rd_data = {16'h0000, w_lane_rd[1], w_lane_rd[0]};
        end else begin
            w_rd_data = {w_lane_rd[3], w_lane_rd[2], w_lane_rd[1], w_lane_rd[0]};
        end
    end

    assign data_o = w_misalign ? 32'h0000_0000 : w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Directed self-checking bench for data_memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int DEPTH_BYTES = 1024;

    localparam logic [1:0] c_B = 2'b00;
    localparam logic [1:0] c_H = 2'b01;
    localparam logic [1:0] c_W = 2'b10;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        mem_write_i;
    logic [1:0]  req_size_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    data_memory #(.DEPTH_BYTES(DEPTH_BYTES)) u_dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .mem_write_i (mem_write_i),
        .req_size_i  (req_size_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        .data_o      (data_o),
        .misalign_o  (misalign_o)
`else
        .data_o      (data_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        req_size_i  = size;
        addr_i      = addr;
        data_i      = data;
        mem_write_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_write_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] exp);
        req_size_i = size;
        addr_i     = addr;
        #1;
        check(tag, data_o, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i     = 1'b0;
        mem_write_i = 1'b0;
        req_size_i  = c_W;
        addr_i      = 32'h0;
        data_i      = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;

        rd("rst_w0", c_W, 32'd0, 32'h0000_0000);
        rd("rst_w1", c_W, 32'd1, 32'h0000_0000);
        rd("rst_w2", c_W, 32'd2, 32'h0000_0000);
        rd("rst_b0", c_B, 32'd0, 32'h0000_0000);
        rd("rst_h0", c_H, 32'd0, 32'h0000_0000);

        do_write(c_B, 32'd0, 32'hAABB_CCFF);
        rd("byte_b0", c_B, 32'd0, 32'h0000_00FF);
        rd("byte_b1", c_B, 32'd1, 32'h0000_0000);
        rd("byte_b2", c_B, 32'd2, 32'h0000_0000);
        rd("byte_w0", c_W, 32'd0, 32'h0000_00FF);

        do_write(c_H, 32'd0, 32'h0000_FFFF);
        rd("half_h0", c_H, 32'd0, 32'h0000_FFFF);
        rd("half_h1", c_H, 32'd1, 32'h0000_00FF);
        rd("half_h2", c_H, 32'd2, 32'h0000_0000);
        rd("half_w0", c_W, 32'd0, 32'h0000_FFFF);

        do_write(c_W, 32'd4, 32'hAABB_CCDD);
        rd("word_b4", c_B, 32'd4, 32'h0000_00DD);
        rd("word_b5", c_B, 32'd5, 32'h0000_00CC);
        rd("word_b6", c_B, 32'd6, 32'h0000_00BB);
        rd("word_b7", c_B, 32'd7, 32'h0000_00AA);
        rd("word_s11", 2'b11, 32'd4, 32'hAABB_CCDD);
`ifndef DATA_MEMORY_ALIGN_CHECK_EN
        rd("word_h5", c_H, 32'd5, 32'h0000_BBCC);
        rd("word_w5", c_W, 32'd5, 32'h00AA_BBCC);
`endif
        rd("word_b8", c_B, 32'd8, 32'h0000_0000);

        // Byte write in the middle of a word leaves the neighbours alone.
        do_write(c_B, 32'd6, 32'h1234_5655);
        rd("merge_w4", c_W, 32'd4, 32'hAA55_CCDD);
        // Upper address bits are ignored.
        rd("alias_w4", c_W, 32'h8000_0404, 32'hAA55_CCDD);

        // Read-during-write: old value before the edge, new one right after.
        @(negedge clk_i);
        req_size_i  = c_W;
        addr_i      = 32'd12;
        data_i      = 32'h1234_5678;
        mem_write_i = 1'b1;
        #1;
        check("rdw_before", data_o, 32'h0000_0000);
        @(posedge clk_i);
        #1;
        mem_write_i = 1'b0;
        check("rdw_after", data_o, 32'h1234_5678);

`ifndef DATA_MEMORY_ALIGN_CHECK_EN
        do_write(c_W, DEPTH_BYTES - 2, 32'h1122_3344);
        rd("wrap_w", c_W, DEPTH_BYTES - 2, 32'h1122_3344);
        rd("wrap_b_last1", c_B, DEPTH_BYTES - 2, 32'h0000_0044);
        rd("wrap_b_last", c_B, DEPTH_BYTES - 1, 32'h0000_0033);
        rd("wrap_b0", c_B, 32'd0, 32'h0000_0022);
        rd("wrap_b1", c_B, 32'd1, 32'h0000_0011);
        do_write(c_H, DEPTH_BYTES - 1, 32'h0000_BEEF);
        rd("wrap_h", c_H, DEPTH_BYTES - 1, 32'h0000_BEEF);
        rd("wrap_h_b0", c_B, 32'd0, 32'h0000_00BE);
`else
        do_write(c_W, 32'd0, 32'h0102_0304);
        req_size_i  = c_W;
        addr_i      = 32'd0;
        #1;
        check("mis_aligned_flag", {31'd0, misalign_o}, 32'd0);
        @(negedge clk_i);
        req_size_i  = c_W;
        addr_i      = 32'd2;
        data_i      = 32'hDEAD_BEEF;
        mem_write_i = 1'b1;
        #1;
        check("mis_word_flag", {31'd0, misalign_o}, 32'd1);
        check("mis_word_data", data_o, 32'h0000_0000);
        @(posedge clk_i);
        #1;
        mem_write_i = 1'b0;
        rd("mis_w0_kept", c_W, 32'd0, 32'h0102_0304);
        rd("mis_w4_kept", c_W, 32'd4, 32'hAA55_CCDD);
        req_size_i = c_H;
        addr_i     = 32'd1;
        #1;
        check("mis_half_flag", {31'd0, misalign_o}, 32'd1);
        req_size_i = c_B;
        addr_i     = 32'd3;
        #1;
        check("mis_byte_flag", {31'd0, misalign_o}, 32'd0);
`endif

        // Asynchronous clear between edges, no clock edge required.
        @(negedge clk_i);
        req_size_i = c_W;
        addr_i     = 32'd4;
        #1;
        check("pre_rst_w4", data_o, 32'hAA55_CCDD);
        #1;
        reset_i = 1'b0;
        #1;
        check("async_rst_w4", data_o, 32'h0000_0000);

        // Writes attempted while reset is held are discarded.
        mem_write_i = 1'b1;
        data_i      = 32'hCAFE_F00D;
        addr_i      = 32'd4;
        @(posedge clk_i);
        #1;
        mem_write_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        rd("rst_inhibit_w4", c_W, 32'd4, 32'h0000_0000);
        rd("rst_clear_w12", c_W, 32'd12, 32'h0000_0000);

        // First write lands on the first edge after release.
        do_write(c_W, 32'd8, 32'h5A5A_A5A5);
        rd("post_rst_w8", c_W, 32'd8, 32'h5A5A_A5A5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
